div_share_arbiter: RTL and testbench



---
 rtl/div_pkg.sv | 36 +++
 rtl/div_restore_step.sv | 29 ++
 rtl/div_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_div_share_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider-sharing arbiter: state encoding,
// default sizes and the round-robin search.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_NREQ  = 4;
  localparam int RR_W      = 3;
  localparam int RR_N      = 8;

  // First valid requester after ptr, wrapping at nreq; 0 when nothing is valid.
  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] ptr,
                                               input logic [RR_N-1:0] valid,
                                               input int              nreq);
    logic [RR_W-1:0] gnt;
    logic            found;
    int              idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= RR_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= nreq) idx = idx - nreq;
      if (i <= nreq && !found && valid[idx[RR_W-1:0]]) begin
        gnt   = idx[RR_W-1:0];
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restore_step #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  logic [WIDTH-1:0] partial;
  logic [WIDTH:0]   trial;

  // rem stays below 2^(i) after i steps, so its MSB is never shifted out.
  always_comb begin
    partial = {rem[WIDTH-2:0], dq[WIDTH-1]};
    trial   = {1'b0, partial} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      dq_next  = {dq[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = partial;
      dq_next  = {dq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative restoring divider between NREQ
// requesters; one quotient bit per clock, result held until accepted.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offered to the round-robin winner
// CALC  | one restoring step per clock, WIDTH steps
// DONE  | result held on rsp_*, waiting for rsp_ready
module div_share_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_div_by_zero,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [RR_W-1:0]  gnt_full;
  logic [IDW-1:0]   gnt;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dq;

  assign gnt_full     = rr_next(RR_W'(rr_ptr_q), RR_N'(req_valid), NREQ);
  assign gnt          = gnt_full[IDW-1:0];
  assign any_valid    = |req_valid;
  assign sel_dividend = req_dividend[int'(gnt)*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor[int'(gnt)*WIDTH +: WIDTH];
  assign accept       = |(req_valid & req_ready);

  if (IDW < RR_W) begin : g_pad
    logic unused_gnt_hi;
    assign unused_gnt_hi = ^gnt_full[RR_W-1:IDW];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && any_valid) req_ready[gnt] = 1'b1;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dq       (dq_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .dq_next  (step_dq)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dq_d     = dq_q;
    dvs_d    = dvs_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d     = gnt;
          rr_ptr_d = gnt;
          cnt_d    = '0;
          dvs_d    = sel_divisor;
          if (sel_divisor != '0) begin
            state_d = CALC;
            rem_d   = '0;
            dq_d    = sel_dividend;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            rem_d   = sel_dividend;
            dq_d    = '1;
            dbz_d   = 1'b1;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      id_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dq_q     <= dq_d;
      dvs_q    <= dvs_d;
      dbz_q    <= dbz_d;
    end
  end

  assign rsp_valid       = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign rsp_id          = id_q;
  assign rsp_quotient    = dq_q;
  assign rsp_remainder   = rem_q;
  assign rsp_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: hand-computed divisions, latency,
// hold stability, reset mid-operation and round-robin grant order.
module tb_div_share_arbiter;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_div_by_zero;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  div_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dividend    (req_dividend),
    .req_divisor     (req_divisor),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_quotient    (rsp_quotient),
    .rsp_remainder   (rsp_remainder),
    .rsp_div_by_zero (rsp_div_by_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from requester k, wait for the result and retire it.
  task automatic run_op(input int k, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] qe, input logic [2:0] re,
                        input logic dz, input int hold);
    int w;
    req_dividend[k*WIDTH +: WIDTH] = a;
    req_divisor[k*WIDTH +: WIDTH]  = b;
    req_valid    = '0;
    req_valid[k] = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << k);
    @(negedge clk);
    req_valid = '0;
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("latency", 32'(w), dz ? 32'd0 : 32'(WIDTH));
    chk("rsp_id", 32'(rsp_id), 32'(k));
    chk("quotient", 32'(rsp_quotient), 32'(qe));
    chk("remainder", 32'(rsp_remainder), 32'(re));
    chk("dbz", 32'(rsp_div_by_zero), 32'(dz));
    chk("busy_done", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      req_valid = 4'b1000;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_q", 32'(rsp_quotient), 32'(qe));
      chk("hold_r", 32'(rsp_remainder), 32'(re));
      chk("hold_id", 32'(rsp_id), 32'(k));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int n;
  int cyc;
  int idx;

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_q", 32'(rsp_quotient), 32'd0);
    chk("rst_r", 32'(rsp_remainder), 32'd0);
    chk("rst_dbz", 32'(rsp_div_by_zero), 32'd0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    rst = 1'b0;

    run_op(0, 3'd6, 3'd3, 3'd2, 3'd0, 1'b0, 0);
    run_op(2, 3'd7, 3'd2, 3'd3, 3'd1, 1'b0, 5);
    run_op(2, 3'd2, 3'd5, 3'd0, 3'd2, 1'b0, 0);
    run_op(1, 3'd5, 3'd0, 3'd7, 3'd5, 1'b1, 0);

    // Reset while the divider is mid-computation (cnt == 1).
    req_dividend[0 +: WIDTH] = 3'd7;
    req_divisor[0 +: WIDTH]  = 3'd1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("mid_cnt", 32'(dut.cnt_q), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'd0);
    chk("mid_rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
    rst = 1'b0;
    run_op(0, 3'd4, 3'd2, 3'd2, 3'd0, 1'b0, 0);

    // Round-robin with every requester valid and the consumer always ready.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_dividend[k*WIDTH +: WIDTH] = 3'd6;
      req_divisor[k*WIDTH +: WIDTH]  = 3'd3;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 5 && cyc < 100) begin
      #1;
      chk("rr_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) begin
        idx = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) idx = k;
        chk("rr_order", 32'(idx), 32'(exp_order[n]));
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_count", 32'(n), 32'd5);
    req_valid = '0;
    repeat (8) @(negedge clk);
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
